// File: rtl/flash_sdram_writer_if.sv
// Bus between the flash reader, the frame writer and the SDRAM write port.
// The writer is the master: it requests bursts and supplies the data words.
interface flash_sdram_writer_if;
  logic        sdram_init_done;
  logic [15:0] mydata_i;
  logic        myvalid_i;
  logic        wr_req;
  logic        wr_ack;
  logic [21:0] wr_addr;
  logic        wr_data_req;
  logic [15:0] wr_data;
  logic        frame_write_done;
  logic        overflow;

  modport master (
    input  sdram_init_done, mydata_i, myvalid_i, wr_ack, wr_data_req,
    output wr_req, wr_addr, wr_data, frame_write_done, overflow
  );

  modport slave (
    output sdram_init_done, mydata_i, myvalid_i, wr_ack, wr_data_req,
    input  wr_req, wr_addr, wr_data, frame_write_done, overflow
  );
endinterface

// File: rtl/flash_sdram_writer.sv
// Buffers pixel words from the flash reader in a show-ahead FIFO and writes
// them to SDRAM in fixed-size bursts until one full frame has been stored.
module flash_sdram_writer #(
  parameter logic [21:0] BASE_ADDR   = 22'h000000,
  parameter int          BURST       = 8,
  parameter int          FRAME_WORDS = 130560,
  parameter int          FIFO_DEPTH  = 32
) (
  input  logic                  clk_ref,
  input  logic                  rst,
  flash_sdram_writer_if.master  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(BURST + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_REQ  = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic [WW-1:0]   words_q, words_d;
  logic [21:0]     addr_q, addr_d;
  logic            overflow_q;
  logic [15:0]     last_q;
  logic [15:0]     mem_q [FIFO_DEPTH];

  logic            push_req_s;
  logic            full_s;
  logic            push_s;
  logic            pop_s;
  logic            burst_end_s;

  // A pull is honoured only inside a burst with beats remaining and data present.
  assign push_req_s  = bus.myvalid_i && (state_q != S_DONE);
  assign full_s      = (count_q == CW'(FIFO_DEPTH));
  assign push_s      = push_req_s && !full_s;
  assign pop_s       = bus.wr_data_req && (state_q == S_XFER) &&
                       (beats_q != BW'(0)) && (count_q != CW'(0));
  assign burst_end_s = pop_s && (beats_q == BW'(1));

  assign bus.wr_req           = (state_q == S_REQ);
  assign bus.wr_addr          = addr_q;
  assign bus.frame_write_done = (state_q == S_DONE);
  assign bus.overflow         = overflow_q;
  // Show-ahead head word; once drained the last popped word is held.
  assign bus.wr_data          = (count_q != CW'(0)) ? mem_q[rd_ptr_q] : last_q;

  // Next-state, burst bookkeeping and address advance.
  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    addr_d  = addr_q;
    words_d = words_q;
    case (state_q)
      S_IDLE: begin
        if (bus.sdram_init_done) state_d = S_FILL;
        else                     state_d = state_q;
      end
      S_FILL: begin
        if (count_q >= CW'(BURST)) state_d = S_REQ;
        else                       state_d = state_q;
      end
      S_REQ: begin
        if (bus.wr_ack) begin
          beats_d = BW'(BURST);
          state_d = S_XFER;
        end else begin
          state_d = state_q;
        end
      end
      S_XFER: begin
        if (pop_s) begin
          beats_d = beats_q - BW'(1);
          if (burst_end_s) begin
            addr_d  = addr_q + 22'(BURST);
            words_d = words_q - WW'(BURST);
            if (words_q == WW'(BURST)) state_d = S_DONE;
            else                       state_d = S_FILL;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy follows push/pop; a simultaneous pair leaves it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers: state, pointers, counters and sticky overflow.
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beats_q    <= '0;
      words_q    <= WW'(FRAME_WORDS);
      addr_q     <= BASE_ADDR;
      overflow_q <= 1'b0;
      last_q     <= 16'h0000;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      beats_q    <= beats_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
      overflow_q <= overflow_q | (push_req_s && full_s);
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // FIFO storage; contents are don't-care until written, gated by count.
  always_ff @(posedge clk_ref) begin
    if (push_s) mem_q[wr_ptr_q] <= bus.mydata_i;
  end

endmodule

// File: tb/tb_flash_sdram_writer.sv
// Self-checking bench: scoreboard of pushed words, table of bursts, plus
// hand-written overflow, simultaneous push/pop and mid-burst reset sequences.
module tb_flash_sdram_writer;
  localparam logic [21:0] BASE = 22'h3FFFF8;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] sb [$];

  always #5 clk = ~clk;

  flash_sdram_writer_if bus ();

  flash_sdram_writer #(
    .BASE_ADDR(BASE), .BURST(8), .FRAME_WORDS(24), .FIFO_DEPTH(16)
  ) dut (
    .clk_ref(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] first;
    logic [21:0] addr;
    int          extra;
    logic        done;
  } vec_t;
  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] d, input bit acc);
    bus.mydata_i  = d;
    bus.myvalid_i = 1'b1;
    if (acc) sb.push_back(d);
    @(negedge clk);
    bus.myvalid_i = 1'b0;
  endtask

  task automatic wait_req(input logic [21:0] ea);
    int n = 0;
    while (bus.wr_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wr_req_rise", {31'd0, bus.wr_req}, 32'd1);
    check("wr_addr", {10'd0, bus.wr_addr}, {10'd0, ea});
  endtask

  // One burst: ack, 8 pulls compared against the scoreboard, optional
  // simultaneous strobes from beat simul_from on, then extra stray pulls.
  task automatic do_burst(input logic [21:0] ea, input int simul_from,
                          input logic [15:0] sdata, input int exp_cnt, input int extra);
    logic [15:0] e;
    wait_req(ea);
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.wr_ack = 1'b0;
    check("wr_req_drop", {31'd0, bus.wr_req}, 32'd0);
    for (int i = 0; i < 8 + extra; i++) begin
      bus.wr_data_req = 1'b1;
      if (i < 8) begin
        if (i >= simul_from) begin
          bus.mydata_i  = sdata + 16'(i - simul_from);
          bus.myvalid_i = 1'b1;
          sb.push_back(bus.mydata_i);
          check("simul_count", 32'(dut.count_q), 32'(exp_cnt));
        end else begin
          bus.myvalid_i = 1'b0;
        end
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          check("wr_data", {16'd0, bus.wr_data}, {16'd0, e});
        end
      end else begin
        bus.myvalid_i = 1'b0;
      end
      @(negedge clk);
    end
    bus.wr_data_req = 1'b0;
    bus.myvalid_i   = 1'b0;
  endtask

  task automatic do_reset(input logic init);
    rst = 1'b1;
    bus.sdram_init_done = init;
    bus.myvalid_i = 1'b0;
    bus.wr_ack = 1'b0;
    bus.wr_data_req = 1'b0;
    bus.mydata_i = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{first: 16'h0001, addr: BASE,          extra: 3, done: 1'b0};
    vecs[1] = '{first: 16'h0009, addr: BASE + 22'd8,  extra: 0, done: 1'b0};
    vecs[2] = '{first: 16'h0011, addr: BASE + 22'd16, extra: 0, done: 1'b1};

    // Reset values while held in reset.
    rst = 1'b1;
    bus.sdram_init_done = 1'b0;
    bus.myvalid_i = 1'b0;
    bus.wr_ack = 1'b0;
    bus.wr_data_req = 1'b0;
    bus.mydata_i = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
    check("rst_wr_addr", {10'd0, bus.wr_addr}, {10'd0, BASE});
    check("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
    check("rst_done", {31'd0, bus.frame_write_done}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);

    // Full frame of three bursts, first one followed by stray pulls.
    do_reset(1'b1);
    for (int v = 0; v < 3; v++) begin
      for (int j = 0; j < 8; j++) strobe(vecs[v].first + 16'(j), 1'b1);
      do_burst(vecs[v].addr, 8, 16'h0000, 0, vecs[v].extra);
      check("count_after", 32'(dut.count_q), 32'd0);
      check("addr_after", {10'd0, bus.wr_addr}, {10'd0, vecs[v].addr + 22'd8});
      check("done_after", {31'd0, bus.frame_write_done}, {31'd0, vecs[v].done});
    end
    strobe(16'h00FF, 1'b0);
    @(negedge clk);
    check("done_strobe_count", 32'(dut.count_q), 32'd0);
    check("done_strobe_ovf", {31'd0, bus.overflow}, 32'd0);
    check("done_sticky", {31'd0, bus.frame_write_done}, 32'd1);

    // Overflow with SDRAM not ready: 17th word dropped.
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) strobe(16'h0100 + 16'(i), i < 16);
    @(negedge clk);
    check("ovf_count", 32'(dut.count_q), 32'd16);
    check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    check("ovf_no_req", {31'd0, bus.wr_req}, 32'd0);
    bus.sdram_init_done = 1'b1;
    do_burst(BASE, 8, 16'h0000, 0, 0);
    do_burst(BASE + 22'd8, 8, 16'h0000, 0, 0);
    check("ovf_drained", 32'(dut.count_q), 32'd0);
    for (int j = 0; j < 8; j++) strobe(16'h0200 + 16'(j), 1'b1);
    do_burst(BASE + 22'd16, 8, 16'h0000, 0, 0);
    check("ovf_done", {31'd0, bus.frame_write_done}, 32'd1);
    check("ovf_still_set", {31'd0, bus.overflow}, 32'd1);

    // Simultaneous push and pop with write pointer wrapping, then read across wrap.
    do_reset(1'b1);
    for (int i = 0; i < 16; i++) strobe(16'h0300 + 16'(i), 1'b1);
    do_burst(BASE, 4, 16'h0400, 12, 0);
    check("simul_count_end", 32'(dut.count_q), 32'd12);
    do_burst(BASE + 22'd8, 8, 16'h0000, 0, 0);
    check("wrap_count", 32'(dut.count_q), 32'd4);
    for (int j = 4; j < 8; j++) strobe(16'h0400 + 16'(j), 1'b1);
    do_burst(BASE + 22'd16, 8, 16'h0000, 0, 0);
    check("wrap_done", {31'd0, bus.frame_write_done}, 32'd1);

    // Reset in the middle of a burst, then a clean restart.
    do_reset(1'b1);
    for (int j = 0; j < 8; j++) strobe(16'h0500 + 16'(j), 1'b1);
    wait_req(BASE);
    bus.wr_ack = 1'b1;
    @(negedge clk);
    bus.wr_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.wr_data_req = 1'b1;
      check("mid_wr_data", {16'd0, bus.wr_data}, {16'd0, sb.pop_front()});
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr_req", {31'd0, bus.wr_req}, 32'd0);
    check("mid_rst_addr", {10'd0, bus.wr_addr}, {10'd0, BASE});
    check("mid_rst_count", 32'(dut.count_q), 32'd0);
    check("mid_rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
    @(negedge clk);
    bus.wr_data_req = 1'b0;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    for (int j = 0; j < 8; j++) strobe(16'h0600 + 16'(j), 1'b1);
    do_burst(BASE, 8, 16'h0000, 0, 0);
    check("restart_addr", {10'd0, bus.wr_addr}, {10'd0, BASE + 22'd8});
    check("restart_count", 32'(dut.count_q), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flash_sdram_writer.md
FLASH_SDRAM_WRITER -- requirements
Module: flash_sdram_writer

Interface
REQ-001 Parameter BASE_ADDR, default 22'h000000: SDRAM word address of the first frame word.
REQ-002 Parameter BURST, default 8: words per SDRAM write burst.
REQ-003 Parameter FRAME_WORDS, default 130560 (480x272): words per frame; SHALL be an integer multiple of BURST.
REQ-004 Parameter FIFO_DEPTH, default 32: power of two, at least 2*BURST.
REQ-005 clk_ref  in  1  single clock domain; all logic on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 sdram_init_done  in  1  level; SDRAM is ready for writes.
REQ-008 mydata_i  in  16  pixel word from the flash reader.
REQ-009 myvalid_i  in  1  one-cycle strobe; mydata_i is valid in the same cycle.
REQ-010 wr_req  out  1  burst write request to the SDRAM controller.
REQ-011 wr_ack  in  1  one-cycle acceptance of wr_req.
REQ-012 wr_addr  out  22  burst start address; stable while wr_req is high and during XFER.
REQ-013 wr_data_req  in  1  controller pulls one word per high cycle.
REQ-014 wr_data  out  16  FIFO head word (show-ahead), valid in every cycle wr_data_req is high.
REQ-015 frame_write_done  out  1  level; the whole frame has been written.
REQ-016 overflow  out  1  sticky; a strobe arrived while the FIFO was full.

Function
REQ-017 FIFO: FIFO_DEPTH x 16, show-ahead.
  - Push: on myvalid_i when not full and state != DONE.
  - Pop: on wr_data_req in XFER while beats_left > 0.
  - Push and pop in the same cycle: count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-018 Push while full: word dropped, overflow set to 1 until rst, count unchanged.
REQ-019 Counters:
  - words_left resets to FRAME_WORDS.
  - addr resets to BASE_ADDR.
  - beats_left is sized for 0..BURST.
REQ-020 State IDLE: wr_req=0. Go to FILL when sdram_init_done=1. Pushes are accepted in IDLE.
REQ-021 State FILL: go to REQ when fifo count >= BURST (registered, next cycle).
REQ-022 State REQ:
  - wr_req=1 and wr_addr=addr.
  - On wr_ack: wr_req drops the following cycle, beats_left=BURST, state goes to XFER.
REQ-023 State XFER: each wr_data_req pops one word and decrements beats_left. When beats_left reaches 0:
  - addr += BURST (22-bit wrap);
  - words_left -= BURST;
  - go to DONE if words_left becomes 0, else to FILL.
REQ-024 wr_data_req in XFER with beats_left = 0, or in any other state: ignored (no pop, no counter change).
REQ-025 wr_data_req with the FIFO empty cannot occur because a burst starts only with count >= BURST. If it does occur, it is ignored and wr_data holds its last value.
REQ-026 State DONE: frame_write_done=1 and wr_req=0. myvalid_i is ignored (no push, no overflow). DONE is exited only by rst.
REQ-027 sdram_init_done falling after IDLE: no effect on the state machine.
REQ-028 Latency: a push is visible in count one cycle later; wr_req rises one cycle after count first reaches BURST in FILL.

Reset
REQ-029 While rst=1 and on release, every output is at its reset value: wr_req=0, wr_addr=BASE_ADDR, wr_data=0, frame_write_done=0, overflow=0.
REQ-030 On rst: state=IDLE, FIFO emptied, pointers and count=0, counters reloaded per REQ-019.
REQ-031 rst asserted mid-burst aborts the burst immediately (asynchronous); no further pops occur.

Verification
REQ-032 Basic burst: FRAME_WORDS=16, 8 strobes 0x0001..0x0008 -> wr_req=1 with wr_addr=0; after wr_ack and 8 wr_data_req, wr_data sequence is 0x0001..0x0008; then state FILL and addr=8.
REQ-033 Full frame: FRAME_WORDS=16, 16 strobes, controller acks every request -> two bursts at addresses 0 and 8; frame_write_done=1 one cycle after the 16th pop; a 17th strobe is ignored and overflow stays 0.
REQ-034 Overflow: FIFO_DEPTH=16, sdram_init_done held 0, 17 strobes -> count=16 and overflow=1; the 17th word is never emitted.
REQ-035 Simultaneous push and pop: in XFER, myvalid_i and wr_data_req high together for 4 cycles -> count constant; word order preserved across the pointer wrap.
REQ-036 Reset mid-burst: rst pulsed after 3 of 8 pops -> wr_req=0, wr_addr=BASE_ADDR, count=0, state IDLE; a fresh 8-word fill restarts at address BASE_ADDR.
REQ-037 Stray pulls: wr_data_req held high 3 cycles beyond the 8 beats -> exactly 8 pops, count and addr unaffected by the extra cycles.
